// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: stimulus/capture bus of the truth-table sweeper (compare signals only with SWEEP_COMPARE_EN)
interface truth_table_sweeper_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] tt;
`ifdef SWEEP_COMPARE_EN
  logic [7:0] expected;
  logic       mismatch;
  logic [2:0] mismatch_idx;
  modport master (output start, y, expected, input a, b, c, busy, done, tt, mismatch, mismatch_idx);
  modport slave (input start, y, expected, output a, b, c, busy, done, tt, mismatch, mismatch_idx);
`else
  modport master (output start, y, input a, b, c, busy, done, tt);
  modport slave (input start, y, output a, b, c, busy, done, tt);
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives {a,b,c}=0..7, samples y after a settle time, builds an 8-bit truth table; SWEEP_COMPARE_EN adds reference compare
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  truth_table_sweeper_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t        r_state, w_next;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tt, w_tt_smp;
  logic          w_accept, w_last;
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be 1..255");
  end
  assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_last   = r_state == SAMPLE && r_idx == 3'd7;
  // Truth table as it will look after the current SAMPLE cycle
  always_comb begin
    w_tt_smp        = r_tt;
    w_tt_smp[r_idx] = bus.y;
  end
  // Next state: accept start from IDLE/DONE, count down settle, sample, stop after vector 7
  always_comb begin
    w_next = w_accept ? SETTLE :
             (r_state == SETTLE && r_cnt == '0) ? SAMPLE :
             (r_state == SAMPLE) ? (w_last ? DONE : SETTLE) : r_state;
  end
  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Vector index, settle counter and captured table
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_tt  <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_cnt <= RELOAD;
      r_tt  <= '0;
    end else if (r_state == SETTLE && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == SAMPLE) begin
      r_tt <= w_tt_smp;
      if (!w_last) begin
        r_idx <= r_idx + 3'd1;
        r_cnt <= RELOAD;
      end
    end
  end
  assign {bus.a, bus.b, bus.c} = r_idx;
  assign bus.busy = r_state == SETTLE || r_state == SAMPLE;
  assign bus.done = r_state == DONE;
  assign bus.tt   = r_tt;
`ifdef SWEEP_COMPARE_EN
  logic [7:0] r_exp, w_diff;
  logic       r_mis;
  logic [2:0] r_mis_idx, w_low;
  assign w_diff = w_tt_smp ^ r_exp;
  // Lowest differing table index, scanning down so bit 0 wins
  always_comb begin
    w_low = '0;
    for (int i = 7; i >= 0; i--) if (w_diff[i]) w_low = 3'(i);
  end
  // Latch reference at accept, evaluate compare on the edge entering DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exp     <= '0;
      r_mis     <= 1'b0;
      r_mis_idx <= '0;
    end else if (w_accept) begin
      r_exp     <= bus.expected;
      r_mis     <= 1'b0;
      r_mis_idx <= '0;
    end else if (w_last) begin
      r_mis     <= |w_diff;
      r_mis_idx <= w_low;
    end
  end
  assign bus.mismatch     = r_mis;
  assign bus.mismatch_idx = r_mis_idx;
`endif
endmodule
